// File: rtl/dyn_shiftrow_unit_if.sv
// dyn_shiftrow_unit_if: valid/ready stream and offset-config bundle for dyn_shiftrow_unit.
interface dyn_shiftrow_unit_if #(
  parameter int NB = 4,
  parameter int OW = $clog2(NB)
);
  logic              cfg_we;
  logic [4*OW-1:0]   cfg_off;
  logic              in_valid;
  logic              in_ready;
  logic              in_inv;
  logic [32*NB-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [32*NB-1:0]  out_data;
  logic [15:0]       beat_cnt;
  modport master (
    output cfg_we, cfg_off, in_valid, in_inv, in_data, out_ready,
    input  in_ready, out_valid, out_data, beat_cnt
  );
  modport slave (
    input  cfg_we, cfg_off, in_valid, in_inv, in_data, out_ready,
    output in_ready, out_valid, out_data, beat_cnt
  );
endinterface

// File: rtl/dyn_shiftrow_unit.sv
// dyn_shiftrow_unit: registered ShiftRows/InvShiftRows with per-row dynamic offsets
// behind a 2-entry skid buffer.
module dyn_shiftrow_unit #(
  parameter int NB = 4,
  parameter int OW = $clog2(NB),
  parameter logic [4*OW-1:0] RST_OFF = {OW'(3), OW'(2), OW'(1), OW'(0)}
) (
  input logic clk,
  input logic rst,
  dyn_shiftrow_unit_if.slave bus
);
  localparam int W = 32 * NB;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t          r_state, w_next;
  logic [4*OW-1:0] r_off;
  logic [W-1:0]    r_out, r_skid, w_shift;
  logic            r_in_ready;
  logic [15:0]     r_cnt;
  logic            w_acc, w_xfer;
  assign w_acc  = bus.in_valid & r_in_ready;
  assign w_xfer = (r_state != EMPTY) & bus.out_ready;
  // Byte (r,c) sits at data[W-1-8*(4c+r) -: 8]; offsets are reduced mod NB.
  always_comb begin
    int e, s;
    w_shift = '0;
    for (int r = 0; r < 4; r++) begin
      e = int'(r_off[r*OW +: OW]) % NB;
      for (int c = 0; c < NB; c++) begin
        s = bus.in_inv ? (c - e + NB) % NB : (c + e) % NB;
        w_shift[W-1-8*(4*c+r) -: 8] = bus.in_data[W-1-8*(4*s+r) -: 8];
      end
    end
  end
  always_comb begin
    w_next = r_state;
    if (r_state == EMPTY) w_next = w_acc ? ONE : EMPTY;
    else if (r_state == ONE) w_next = (w_acc & !w_xfer) ? TWO : (!w_acc & w_xfer) ? EMPTY : ONE;
    else w_next = w_xfer ? ONE : TWO;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b0;
      r_off      <= RST_OFF;
      r_cnt      <= '0;
      r_out      <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != TWO);
      if (bus.cfg_we) r_off <= bus.cfg_off;
      if (w_xfer) r_cnt <= r_cnt + 16'd1;
      if (w_acc && (r_state == EMPTY || w_xfer)) r_out <= w_shift;
      else if (w_xfer && r_state == TWO) r_out <= r_skid;
      if (w_acc && r_state == ONE && !w_xfer) r_skid <= w_shift;
    end
  end
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = (r_state != EMPTY);
  assign bus.out_data  = r_out;
  assign bus.beat_cnt  = r_cnt;
endmodule

// File: tb/tb_dyn_shiftrow_unit.sv
// tb_dyn_shiftrow_unit: directed NB=4 checks plus randomized NB=4/6/8 streams
// scored against a byte-array model of the row rotations.
module tb_dyn_shiftrow_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic seen = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [255:0] sq [3][$];
  int moff [3][4];
  int mcnt [3];
  localparam logic [127:0] X0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] XF = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [127:0] XI = 128'h000d0a0704010e0b0805020f0c090603;
  always #5 clk = ~clk;
  dyn_shiftrow_unit_if #(.NB(4)) b4 ();
  dyn_shiftrow_unit_if #(.NB(6)) b6 ();
  dyn_shiftrow_unit_if #(.NB(8)) b8 ();
  dyn_shiftrow_unit #(.NB(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
  dyn_shiftrow_unit #(.NB(6)) u6 (.clk(clk), .rst(rst), .bus(b6));
  dyn_shiftrow_unit #(.NB(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
  always @(posedge clk or posedge rst) seen <= !rst;
  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  // Row r of the state is rotated left (forward) or right (inverse) by off_r mod nb.
  function automatic logic [255:0] ref_shift(input logic [255:0] d, input int nb, input int o[4], input logic inv);
    logic [7:0] row [8];
    logic [255:0] q = '0;
    for (int r = 0; r < 4; r++) begin
      int e = o[r] % nb;
      for (int c = 0; c < nb; c++) row[c] = d[8*(4*nb-1-4*c-r) +: 8];
      for (int c = 0; c < nb; c++) q[8*(4*nb-1-4*c-r) +: 8] = row[inv ? (c - e + nb) % nb : (c + e) % nb];
    end
    return q;
  endfunction
  task automatic mon(input int k, input int nb, input int ow, input logic iv, input logic ir, input logic inv,
                     input logic we, input logic [11:0] coff, input logic [255:0] id, input logic ov,
                     input logic ordy, input logic [255:0] od, input logic [15:0] bc);
    logic mready = seen && sq[k].size() < 2;
    chk($sformatf("in_ready[%0d]", k), 256'(ir), 256'(mready));
    chk($sformatf("out_valid[%0d]", k), 256'(ov), 256'(sq[k].size() != 0));
    chk($sformatf("beat_cnt[%0d]", k), 256'(bc), 256'(16'(mcnt[k])));
    if (sq[k].size() != 0) chk($sformatf("out_data[%0d]", k), od, sq[k][0]);
    if (sq[k].size() != 0 && ordy) begin
      void'(sq[k].pop_front());
      mcnt[k]++;
    end
    if (iv && mready) sq[k].push_back(ref_shift(id, nb, moff[k], inv));
    if (we) for (int r = 0; r < 4; r++) moff[k][r] = int'((coff >> (r * ow)) & ((12'd1 << ow) - 12'd1));
  endtask
  task automatic rmon(input int k, input logic ov, input logic [255:0] od, input logic [15:0] bc);
    sq[k].delete();
    mcnt[k] = 0;
    for (int r = 0; r < 4; r++) moff[k][r] = r;
    chk($sformatf("rst_out_valid[%0d]", k), 256'(ov), 256'(0));
    chk($sformatf("rst_out_data[%0d]", k), od, 256'(0));
    chk($sformatf("rst_beat_cnt[%0d]", k), 256'(bc), 256'(0));
  endtask
  always @(negedge clk) begin
    if (rst) begin
      rmon(0, b4.out_valid, 256'(b4.out_data), b4.beat_cnt);
      rmon(1, b6.out_valid, 256'(b6.out_data), b6.beat_cnt);
      rmon(2, b8.out_valid, 256'(b8.out_data), b8.beat_cnt);
    end else begin
      mon(0, 4, 2, b4.in_valid, b4.in_ready, b4.in_inv, b4.cfg_we, 12'(b4.cfg_off), 256'(b4.in_data),
          b4.out_valid, b4.out_ready, 256'(b4.out_data), b4.beat_cnt);
      mon(1, 6, 3, b6.in_valid, b6.in_ready, b6.in_inv, b6.cfg_we, b6.cfg_off, 256'(b6.in_data),
          b6.out_valid, b6.out_ready, 256'(b6.out_data), b6.beat_cnt);
      mon(2, 8, 3, b8.in_valid, b8.in_ready, b8.in_inv, b8.cfg_we, b8.cfg_off, b8.in_data,
          b8.out_valid, b8.out_ready, b8.out_data, b8.beat_cnt);
    end
  end
  task automatic beat4(input logic [127:0] d, input logic inv);
    b4.in_valid = 1'b1;
    b4.in_inv = inv;
    b4.in_data = d;
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
  endtask
  task automatic tick;
    @(posedge clk); #1;
  endtask
  initial begin
    logic [255:0] rnd;
    int sent;
    logic acc;
    b4.cfg_we = 0; b4.cfg_off = '0; b4.in_valid = 0; b4.in_inv = 0; b4.in_data = '0; b4.out_ready = 1;
    b6.cfg_we = 0; b6.cfg_off = '0; b6.in_valid = 0; b6.in_inv = 0; b6.in_data = '0; b6.out_ready = 1;
    b8.cfg_we = 0; b8.cfg_off = '0; b8.in_valid = 0; b8.in_inv = 0; b8.in_data = '0; b8.out_ready = 1;
    repeat (2) tick;
    rst = 1'b0;
    tick;
    chk("reset_in_ready", 256'(b4.in_ready), 256'(1));
    beat4(X0, 1'b0);
    chk("t1_forward", 256'(b4.out_data), 256'(XF));
    beat4(X0, 1'b1);
    chk("t2_inverse", 256'(b4.out_data), 256'(XI));
    beat4(XF, 1'b1);
    chk("t2_round_trip", 256'(b4.out_data), 256'(X0));
    b4.cfg_we = 1'b1; b4.cfg_off = 8'h00;
    tick;
    b4.cfg_we = 1'b0;
    beat4(X0, 1'b0);
    chk("t3_zero_fwd", 256'(b4.out_data), 256'(X0));
    beat4(X0, 1'b1);
    chk("t3_zero_inv", 256'(b4.out_data), 256'(X0));
    b4.cfg_we = 1'b1; b4.cfg_off = 8'he4;
    beat4(X0, 1'b0);
    b4.cfg_we = 1'b0;
    chk("t3_cfg_same_cycle_old", 256'(b4.out_data), 256'(X0));
    beat4(X0, 1'b0);
    chk("t3_cfg_new", 256'(b4.out_data), 256'(XF));
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    sent = 0;
    for (int cyc = 0; cyc < 100 && sent < 8; cyc++) begin
      b4.in_valid = 1'b1;
      b4.in_inv = 1'b0;
      b4.in_data = X0 ^ {16{8'(sent * 17 + 1)}};
      b4.out_ready = (cyc >= 3);
      acc = b4.in_ready;
      tick;
      if (acc) sent++;
      if (cyc == 1) chk("t4_ready_drop", 256'(b4.in_ready), 256'(0));
    end
    b4.in_valid = 1'b0;
    b4.out_ready = 1'b1;
    repeat (4) tick;
    chk("t4_beat_cnt", 256'(b4.beat_cnt), 256'(8));
    b4.out_ready = 1'b0;
    beat4(X0, 1'b1);
    beat4(X0, 1'b0);
    chk("t5_full", 256'(b4.in_ready), 256'(0));
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_out_valid", 256'(b4.out_valid), 256'(0));
    chk("t5_rst_beat_cnt", 256'(b4.beat_cnt), 256'(0));
    chk("t5_rst_out_data", 256'(b4.out_data), 256'(0));
    tick;
    rst = 1'b0;
    tick;
    chk("t5_ready_after", 256'(b4.in_ready), 256'(1));
    b4.out_ready = 1'b1;
    beat4(X0, 1'b0);
    chk("t5_rst_offsets", 256'(b4.out_data), 256'(XF));
    tick;
    for (int cyc = 0; cyc < 40000 && mcnt[2] < 10000; cyc++) begin
      for (int i = 0; i < 8; i++) rnd[32*i +: 32] = $urandom;
      b4.in_valid = ($urandom % 4) != 0; b4.in_inv = $urandom % 2; b4.in_data = rnd[127:0];
      b4.cfg_we = ($urandom % 16) == 0; b4.cfg_off = 8'($urandom); b4.out_ready = ($urandom % 3) != 0;
      b6.in_valid = ($urandom % 4) != 0; b6.in_inv = $urandom % 2; b6.in_data = rnd[191:0];
      b6.cfg_we = ($urandom % 16) == 0; b6.cfg_off = 12'($urandom); b6.out_ready = ($urandom % 3) != 0;
      b8.in_valid = ($urandom % 4) != 0; b8.in_inv = $urandom % 2; b8.in_data = rnd;
      b8.cfg_we = ($urandom % 16) == 0; b8.cfg_off = 12'($urandom); b8.out_ready = ($urandom % 3) != 0;
      tick;
    end
    chk("rand_b8_10k_beats", 256'(mcnt[2] >= 10000), 256'(1));
    b4.in_valid = 0; b6.in_valid = 0; b8.in_valid = 0;
    b4.cfg_we = 0; b6.cfg_we = 0; b8.cfg_we = 0;
    b4.out_ready = 1; b6.out_ready = 1; b8.out_ready = 1;
    repeat (4) tick;
    chk("drain_b4", 256'(sq[0].size()), 256'(0));
    chk("drain_b6", 256'(sq[1].size()), 256'(0));
    chk("drain_b8", 256'(sq[2].size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
